arb_rr_lock: RTL and testbench

Parametrised N-way arbiter that succeeds the fixed 3-requestor arbiter. It selects one owner per cycle from a request vector using either round-robin or fixed priority, chosen at runtime. A requester can lock its grant across cycles, bounded by a hold limit. Grants are registered and one-hot, and the block sits between N bus masters (driver agents) and a single shared resource.

---
 rtl/arb_rr_lock.sv | 97 +++++++++
 tb/tb_arb_rr_lock.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/arb_rr_lock.sv
// N-way arbiter with runtime-selectable round-robin / fixed priority and
// per-requestor grant locking bounded by a hold limit. Grants are registered.
module arb_rr_lock #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic           prio_mode,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [HCW-1:0] HOLD_SAT  = '1;

  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  logic           owner_locked;
  logic           under_limit;
  logic           others_req;
  logic [N-1:0]   cand;
  logic           win_found;
  logic [IDW-1:0] win_idx;

  always_comb begin
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    cand       = req;
    win_found  = 1'b0;
    win_idx    = '0;

    owner_locked = (|gnt_q) && req[gnt_id_q] && lock[gnt_id_q];
    under_limit  = (MAX_HOLD == 0) || (hold_cnt_q < HOLD_LAST);
    others_req   = |(req & ~gnt_q);

    if (owner_locked && (under_limit || !others_req)) begin
      // A limit-reached owner with no competitor keeps the grant; its count stays put.
      if (under_limit && (hold_cnt_q != HOLD_SAT))
        hold_cnt_d = hold_cnt_q + 1'b1;
    end else begin
      if (owner_locked)
        cand = req & ~gnt_q;
      for (int i = 0; i < N; i++) begin
        if (!win_found) begin
          if (prio_mode) begin
            if (cand[i]) begin
              win_found = 1'b1;
              win_idx   = IDW'(i);
            end
          end else if (cand[(int'(ptr_q) + i) % N]) begin
            win_found = 1'b1;
            win_idx   = IDW'((int'(ptr_q) + i) % N);
          end
        end
      end

      hold_cnt_d = '0;
      gnt_d      = '0;
      gnt_id_d   = '0;
      if (win_found) begin
        gnt_d[win_idx] = 1'b1;
        gnt_id_d       = win_idx;
        ptr_d          = IDW'((int'(win_idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_arb_rr_lock.sv
// Directed-vector bench for arb_rr_lock (N=4, MAX_HOLD=4) with hand-computed
// expected grants; each check prints one line.
module tb_arb_rr_lock;

  localparam int N = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW = $clog2(N);

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic           prio_mode;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;

  int n_vec;
  int n_bad;

  arb_rr_lock #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .prio_mode (prio_mode),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Check gnt plus the gnt_valid/gnt_id implied by the expected one-hot value.
  task automatic expect_gnt(input string tag, input logic [N-1:0] exp_gnt);
    logic [IDW-1:0] exp_id;
    exp_id = '0;
    for (int i = 0; i < N; i++)
      if (exp_gnt[i]) exp_id = IDW'(i);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(|exp_gnt));
    check({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] lock_seq [10];

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    req = '0;
    lock = '0;
    prio_mode = 1'b0;

    #3;
    expect_gnt("por", 4'b0000);
    tick();
    expect_gnt("por_edge", 4'b0000);

    // Get owner 2, then reset mid-cycle.
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0100;
    tick();
    expect_gnt("own2", 4'b0100);
    #2;
    rst = 1'b0;
    #1;
    expect_gnt("async_rst", 4'b0000);

    req = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    tick();
    expect_gnt("rst_rel", 4'b0001);
    tick();
    expect_gnt("rr1", 4'b0010);
    tick();
    expect_gnt("rr2", 4'b0100);
    tick();
    expect_gnt("rr3", 4'b1000);
    tick();
    expect_gnt("rr_wrap", 4'b0001);

    prio_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_gnt($sformatf("fix%0d", i), 4'b0001);
    end
    req = 4'b1110;
    tick();
    expect_gnt("fix_drop0", 4'b0010);
    req = 4'b1000;
    tick();
    expect_gnt("fix_only3", 4'b1000);

    // Lock with hold limit: owner 1 locked, requestor 0 competing.
    prio_mode = 1'b0;
    req = 4'b0010;
    lock = 4'b0010;
    tick();
    expect_gnt("lk_start", 4'b0010);
    req = 4'b0011;
    lock_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0001,
                 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_gnt($sformatf("lk%0d", i), lock_seq[i]);
    end

    // Sole locked requester never forced off.
    req = 4'b0100;
    lock = 4'b0100;
    tick();
    expect_gnt("sole_start", 4'b0100);
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_gnt($sformatf("sole%0d", i), 4'b0100);
    end

    lock = 4'b0000;
    req = 4'b0000;
    tick();
    expect_gnt("idle", 4'b0000);

    req = 4'b0100;
    tick();
    expect_gnt("ho_own2", 4'b0100);
    req = 4'b1000;
    tick();
    expect_gnt("handoff", 4'b1000);

    // Lock without request is ignored.
    req = 4'b0001;
    lock = 4'b0010;
    tick();
    expect_gnt("lock_noreq", 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
